// File: rtl/comparator_scan_sequencer_if.sv
// comparator_scan_sequencer_if: link between the scan sequencer and the comparator
// pulse injector. The sequencer drives expect/inject/fire/clear and reads back
// pulser_ready and the two injector error counters.
interface comparator_scan_sequencer_if #(
  parameter int NSTRIPS = 32
);
  logic               fire_pulse;
  logic               pulser_ready;
  logic               compin_inject;
  logic [NSTRIPS-1:0] halfstrips_expect;
  logic               compout_expect;
  logic               halfstrips_errcnt_rst;
  logic               compout_errcnt_rst;
  logic [31:0]        halfstrips_errcnt;
  logic [31:0]        compout_errcnt;

  modport master (
    output fire_pulse, compin_inject, halfstrips_expect, compout_expect,
           halfstrips_errcnt_rst, compout_errcnt_rst,
    input  pulser_ready, halfstrips_errcnt, compout_errcnt
  );

  modport slave (
    input  fire_pulse, compin_inject, halfstrips_expect, compout_expect,
           halfstrips_errcnt_rst, compout_errcnt_rst,
    output pulser_ready, halfstrips_errcnt, compout_errcnt
  );
endinterface

// File: rtl/comparator_scan_sequencer.sv
// comparator_scan_sequencer: walks the comparator pulse injector across a range of
// half-strips. Per strip it sets a one-hot expected pattern, clears the injector
// error counters, fires pulses_per_step pulses through the fire_pulse/pulser_ready
// handshake and folds the resulting error counts into saturating totals.
// Optional feature: define SCAN_FAIL_MAP_EN to keep a per-strip fail bit map;
// without it fail_map is tied to zero and no map register exists.
module comparator_scan_sequencer #(
  parameter int NSTRIPS        = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [15:0]                pulses_per_step,
  input  logic [$clog2(NSTRIPS)-1:0] first_strip,
  input  logic [$clog2(NSTRIPS)-1:0] last_strip,
  input  logic                       inject_mode,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic [$clog2(NSTRIPS)-1:0] cur_strip,
  output logic [5:0]                 fail_steps,
  output logic [31:0]                total_hs_errs,
  output logic [31:0]                total_co_errs,
  output logic [NSTRIPS-1:0]         fail_map,
  comparator_scan_sequencer_if.master inj
);

  localparam int SW = $clog2(NSTRIPS);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_FIRE      = 3'd3;
  localparam logic [2:0] S_WAIT_ACK  = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_EVAL      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0]    state;
  logic [SW-1:0] last_q;
  logic [15:0]   ppp_q;
  logic          inject_q;
  logic [15:0]   pulse_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          fire_q;

  logic          in_wait;
  logic          wait_met;
  logic          tmo_hit;
  logic          start_accept;
  logic          step_fail;
  logic [32:0]   hs_sum;
  logic [32:0]   co_sum;

  // Handshake wait conditions and saturating sums for the current step.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_wait  = 1'b0;
    wait_met = 1'b0;
    case (state)
      S_FIRE:      begin in_wait = 1'b1; wait_met =  inj.pulser_ready; end
      S_WAIT_ACK:  begin in_wait = 1'b1; wait_met = !inj.pulser_ready; end
      S_WAIT_DONE: begin in_wait = 1'b1; wait_met =  inj.pulser_ready; end
      default:     ;
    endcase
    tmo_hit      = in_wait && !wait_met && (tmo_cnt == TMO_LAST);
    start_accept = (state == S_IDLE) && start && !abort;
    step_fail    = (|inj.halfstrips_errcnt) || (|inj.compout_errcnt);
    hs_sum       = {1'b0, total_hs_errs} + {1'b0, inj.halfstrips_errcnt};
    co_sum       = {1'b0, total_co_errs} + {1'b0, inj.compout_errcnt};
  end

  // Scan FSM, latched configuration, handshake timeout and result accumulation.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cur_strip     <= '0;
      last_q        <= '0;
      ppp_q         <= '0;
      inject_q      <= 1'b0;
      pulse_cnt     <= '0;
      tmo_cnt       <= '0;
      fire_q        <= 1'b0;
      timeout_err   <= 1'b0;
      fail_steps    <= '0;
      total_hs_errs <= '0;
      total_co_errs <= '0;
    end else if (abort) begin
      // Results are held; only the sequencing stops.
      state   <= S_IDLE;
      fire_q  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      fire_q <= 1'b0;
      if (in_wait && !wait_met) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (tmo_hit) begin
        // Handshake stalled: report and finish without evaluating the step.
        timeout_err <= 1'b1;
        tmo_cnt     <= '0;
        state       <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              last_q        <= last_strip;
              ppp_q         <= pulses_per_step;
              inject_q      <= inject_mode;
              cur_strip     <= first_strip;
              timeout_err   <= 1'b0;
              fail_steps    <= '0;
              total_hs_errs <= '0;
              total_co_errs <= '0;
              state         <= (first_strip > last_strip) ? S_DONE : S_CLEAR;
            end
          end
          S_CLEAR: begin
            pulse_cnt <= (ppp_q == 16'd0) ? 16'd1 : ppp_q;
            state     <= S_SETTLE;
          end
          S_SETTLE: begin
            tmo_cnt <= '0;
            state   <= S_FIRE;
          end
          S_FIRE: begin
            if (wait_met) begin
              fire_q  <= 1'b1;
              tmo_cnt <= '0;
              state   <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            if (wait_met) begin
              tmo_cnt <= '0;
              state   <= S_WAIT_DONE;
            end
          end
          S_WAIT_DONE: begin
            if (wait_met) begin
              tmo_cnt <= '0;
              if (pulse_cnt == 16'd1) begin
                state <= S_EVAL;
              end else begin
                pulse_cnt <= pulse_cnt - 16'd1;
                state     <= S_FIRE;
              end
            end
          end
          S_EVAL: begin
            total_hs_errs <= hs_sum[32] ? 32'hFFFF_FFFF : hs_sum[31:0];
            total_co_errs <= co_sum[32] ? 32'hFFFF_FFFF : co_sum[31:0];
            if (step_fail && (fail_steps != 6'd63)) begin
              fail_steps <= fail_steps + 6'd1;
            end
            if (cur_strip == last_q) begin
              state <= S_DONE;
            end else begin
              cur_strip <= cur_strip + SW'(1);
              state     <= S_CLEAR;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SCAN_FAIL_MAP_EN
  logic [NSTRIPS-1:0] fail_map_q;

  // Per-strip fail bits: cleared on an accepted start, set when a step fails.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_map_q <= '0;
    end else if (start_accept) begin
      fail_map_q <= '0;
    end else if ((state == S_EVAL) && !abort && !tmo_hit && step_fail) begin
      fail_map_q[cur_strip] <= 1'b1;
    end
  end

  assign fail_map = fail_map_q;
`else
  assign fail_map = '0;
`endif

  // Output decode from registered state.
  assign busy                      = (state != S_IDLE);
  assign done                      = (state == S_DONE);
  assign inj.fire_pulse            = fire_q;
  assign inj.compin_inject         = busy && inject_q;
  assign inj.compout_expect        = busy && inject_q;
  assign inj.halfstrips_expect     = (busy && inject_q) ? (NSTRIPS'(1) << cur_strip) : '0;
  assign inj.halfstrips_errcnt_rst = (state == S_CLEAR);
  assign inj.compout_errcnt_rst    = (state == S_CLEAR);

endmodule
